// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR MAC engine:
//   - fir_state_e : engine FSM states (IDLE / RUN / HOLD)
//   - clog2_f     : ceiling log2, used for tap index widths
//   - acc_width   : accumulator width that cannot overflow over NTAP products
//   - sat_trunc   : signed clamp of a wide accumulator into an out_w-bit range
// sat_trunc is only called when FIR_SAT_EN is defined.
// -----------------------------------------------------------------------------
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fir_state_e;

    // Widest accumulator the saturation helper can handle.
    localparam int SAT_MAXW = 256;

    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // A full-precision product is dw+cw bits; summing nt of them needs
    // clog2(nt) extra guard bits.
    function automatic int acc_width(input int dw, input int cw, input int nt);
        return dw + cw + clog2_f(nt);
    endfunction

    // Clamp acc into [-2^(out_w-1), 2^(out_w-1)-1]. The result keeps the wide
    // width; the caller takes the low out_w bits.
    function automatic logic signed [SAT_MAXW-1:0] sat_trunc(
        input logic signed [SAT_MAXW-1:0] acc,
        input int                         out_w
    );
        logic signed [SAT_MAXW-1:0] one;
        logic signed [SAT_MAXW-1:0] max_v;
        logic signed [SAT_MAXW-1:0] min_v;
        one      = '0;
        one[0]   = 1'b1;
        max_v    = (one <<< (out_w - 1)) - one;
        min_v    = -max_v - one;
        if (acc > max_v) begin
            return max_v;
        end else if (acc < min_v) begin
            return min_v;
        end
        return acc;
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// -----------------------------------------------------------------------------
// fir_mac_unit
// Registered signed multiply-accumulate.
//   clk, rst : clock, asynchronous active-high reset (clears acc)
//   clr      : load accumulator with zero (wins over en)
//   en       : acc <= acc + a*b
//   a, b     : signed operands
//   sum      : combinational acc + a*b, i.e. the value acc takes when en=1.
//              Lets the caller register a result on the same edge that the
//              final product lands.
// -----------------------------------------------------------------------------
module fir_mac_unit #(
    parameter int A_W   = 32,
    parameter int B_W   = 32,
    parameter int ACC_W = 68
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic signed [ACC_W-1:0] sum
);

    logic signed [A_W+B_W-1:0] prod;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [ACC_W-1:0]   acc_d;

    assign prod = a * b;
    // Signed size cast sign-extends the product into the accumulator width.
    assign sum  = acc_q + ACC_W'(prod);

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = sum;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/fir_mac_engine.sv
// -----------------------------------------------------------------------------
// fir_mac_engine
// NTAP-deep signed FIR with a programmable coefficient bank, a sample delay
// line and one shared MAC evaluating one tap per cycle.
//   CLK, Reset          : clock; asynchronous active-high reset
//   tap_we/addr/wdata   : coefficient write, honoured only in IDLE and only
//                         for tap_addr < NTAP
//   x_valid/x_ready/X   : sample input handshake
//   y_valid/y_ready/Y   : result output handshake (Y held until accepted)
//   Done                : high in the cycle the result handshake completes
// Timing: sample accepted at edge 0, taps accumulated on edges 1..NTAP,
// y_valid rises with the last tap, so one result per NTAP+2 cycles.
// Optional macro FIR_SAT_EN: Y is the accumulator clamped to the signed
// OUT_W range; otherwise Y is the low OUT_W bits of the accumulator.
// -----------------------------------------------------------------------------
module fir_mac_engine
    import fir_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int COEF_W = 32,
    parameter int NTAP   = 11,
    parameter int ACC_W  = acc_width(DATA_W, COEF_W, NTAP),
    parameter int OUT_W  = 32
) (
    input  logic                        CLK,
    input  logic                        Reset,
    input  logic                        tap_we,
    input  logic [clog2_f(NTAP)-1:0]    tap_addr,
    input  logic [COEF_W-1:0]           tap_wdata,
    input  logic                        x_valid,
    output logic                        x_ready,
    input  logic [DATA_W-1:0]           X,
    output logic                        y_valid,
    input  logic                        y_ready,
    output logic [OUT_W-1:0]            Y,
    output logic                        Done
);

    localparam int              AW       = clog2_f(NTAP);
    localparam logic [AW-1:0]   LAST_TAP = AW'(NTAP - 1);

    fir_state_e               state_q, state_d;
    logic [AW-1:0]            cnt_q, cnt_d;
    logic signed [DATA_W-1:0] d_q [NTAP];
    logic signed [DATA_W-1:0] d_d [NTAP];
    logic signed [COEF_W-1:0] h_q [NTAP];
    logic signed [COEF_W-1:0] h_d [NTAP];
    logic [OUT_W-1:0]         y_q, y_d;
    logic                     y_valid_q, y_valid_d;

    logic                     accept;
    logic                     coef_we;
    logic                     mac_clr;
    logic                     mac_en;
    logic signed [DATA_W-1:0] mac_a;
    logic signed [COEF_W-1:0] mac_b;
    logic signed [ACC_W-1:0]  mac_sum;
    logic [OUT_W-1:0]         y_conv;

    assign x_ready = (state_q == IDLE);
    assign accept  = x_valid && x_ready;
    // A write in the accepting cycle lands on the same edge as the shift,
    // and taps are only read from the next cycle on, so it takes effect.
    assign coef_we = tap_we && (state_q == IDLE) && (tap_addr <= LAST_TAP);
    assign mac_a   = d_q[cnt_q];
    assign mac_b   = h_q[cnt_q];
    assign y_valid = y_valid_q;
    assign Y       = y_q;

    // Delay line and coefficient bank, one slot per tap.
    genvar gi;
    generate
        for (gi = 0; gi < NTAP; gi++) begin : g_tap
            assign h_d[gi] = (coef_we && (tap_addr == AW'(gi))) ? tap_wdata : h_q[gi];
            if (gi == 0) begin : g_head
                assign d_d[gi] = accept ? X : d_q[gi];
            end else begin : g_body
                assign d_d[gi] = accept ? d_q[gi-1] : d_q[gi];
            end

            always_ff @(posedge CLK or posedge Reset) begin
                if (Reset) begin
                    d_q[gi] <= '0;
                    h_q[gi] <= '0;
                end else begin
                    d_q[gi] <= d_d[gi];
                    h_q[gi] <= h_d[gi];
                end
            end
        end
    endgenerate

    fir_mac_unit #(
        .A_W   (DATA_W),
        .B_W   (COEF_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk (CLK),
        .rst (Reset),
        .clr (mac_clr),
        .en  (mac_en),
        .a   (mac_a),
        .b   (mac_b),
        .sum (mac_sum)
    );

    // Output conversion works on the sum including the final product, so
    // Y is registered on the same edge as the last accumulation.
`ifdef FIR_SAT_EN
    assign y_conv = OUT_W'(sat_trunc(SAT_MAXW'(mac_sum), OUT_W));
`else
    assign y_conv = OUT_W'(mac_sum);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        Done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    mac_clr = 1'b1;
                end
            end
            RUN: begin
                mac_en = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_TAP) begin
                    state_d   = HOLD;
                    y_d       = y_conv;
                    y_valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (y_valid_q && y_ready) begin
                    Done      = 1'b1;
                    y_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

endmodule

// File: tb/tb_fir_mac_engine.sv
// -----------------------------------------------------------------------------
// tb_fir_mac_engine
// Directed bench for fir_mac_engine at default parameters (NTAP=11, 32-bit
// data/coefficients/output). Expected outputs are hand-computed dot products
// of the delay line contents with the coefficients written by the bench.
// -----------------------------------------------------------------------------
module tb_fir_mac_engine;

    localparam int NTAP = 11;

    logic        CLK;
    logic        Reset;
    logic        tap_we;
    logic [3:0]  tap_addr;
    logic [31:0] tap_wdata;
    logic        x_valid;
    logic        x_ready;
    logic [31:0] X;
    logic        y_valid;
    logic        y_ready;
    logic [31:0] Y;
    logic        Done;

    int vectors;
    int miscompares;
    int done_cnt;
    int results;

    fir_mac_engine dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .tap_we    (tap_we),
        .tap_addr  (tap_addr),
        .tap_wdata (tap_wdata),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .X         (X),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .Y         (Y),
        .Done      (Done)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(negedge CLK) begin
        if (Done === 1'b1) begin
            done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #2;
        @(posedge CLK);
        #1;
        Reset = 1'b0;
    endtask

    task automatic write_coef(input logic [3:0] addr, input logic [31:0] val);
        tap_we    = 1'b1;
        tap_addr  = addr;
        tap_wdata = val;
        @(posedge CLK);
        #1;
        tap_we    = 1'b0;
    endtask

    task automatic wait_y(output int lat);
        lat = 0;
        while (y_valid !== 1'b1 && lat < 60) begin
            @(posedge CLK);
            #1;
            lat++;
        end
    endtask

    task automatic offer(input logic [31:0] x);
        int w;
        w = 0;
        while (x_ready !== 1'b1 && w < 100) begin
            @(posedge CLK);
            #1;
            w++;
        end
        X       = x;
        x_valid = 1'b1;
        @(posedge CLK);
        #1;
        x_valid = 1'b0;
    endtask

    // Full transfer with y_ready high: latency, value and Done pulse.
    task automatic xfer(input logic [31:0] x, input logic [31:0] exp, input string tag);
        int lat;
        offer(x);
        wait_y(lat);
        check({tag, " latency"}, lat + 1, NTAP + 1);
        check({tag, " Y"}, Y, exp);
        check({tag, " Done"}, Done, 1'b1);
        results++;
        @(posedge CLK);
        #1;
        check({tag, " y_valid drop"}, y_valid, 1'b0);
        $display("xfer %s: X=%0h Y=%0h latency_edges=%0d", tag, x, Y, lat + 1);
    endtask

    initial begin
        int lat;
        vectors     = 0;
        miscompares = 0;
        done_cnt    = 0;
        results     = 0;
        Reset       = 1'b1;
        tap_we      = 1'b0;
        tap_addr    = '0;
        tap_wdata   = '0;
        x_valid     = 1'b0;
        X           = '0;
        y_ready     = 1'b1;

        // Reset state
        #2;
        check("rst x_ready", x_ready, 1'b1);
        check("rst y_valid", y_valid, 1'b0);
        check("rst Y", Y, 32'h0);
        check("rst Done", Done, 1'b0);
        @(posedge CLK);
        #1;
        Reset = 1'b0;

        // 1: all-ones taps, constant input ramps up to NTAP
        for (int k = 0; k < NTAP; k++) write_coef(4'(k), 32'd1);
        for (int n = 1; n <= 12; n++) begin
            xfer(32'd1, (n < NTAP) ? 32'(n) : 32'(NTAP), $sformatf("ones%0d", n));
        end

        // 2: impulse response reads back the coefficients in order
        do_reset();
        for (int k = 0; k < NTAP; k++) write_coef(4'(k), 32'(k + 1));
        xfer(32'd1, 32'd1, "imp0");
        for (int n = 1; n < NTAP; n++) begin
            xfer(32'd0, 32'(n + 1), $sformatf("imp%0d", n));
        end

        // 3: backpressure; delay line now [2,0,...] so Y=2
        y_ready = 1'b0;
        offer(32'd2);
        wait_y(lat);
        check("bp latency", lat + 1, NTAP + 1);
        for (int c = 0; c < 5; c++) begin
            check("bp y_valid", y_valid, 1'b1);
            check("bp Y", Y, 32'd2);
            check("bp x_ready", x_ready, 1'b0);
            check("bp Done", Done, 1'b0);
            @(posedge CLK);
            #1;
        end
        y_ready = 1'b1;
        #1;
        check("bp Done on ready", Done, 1'b1);
        results++;
        @(posedge CLK);
        #1;
        check("bp y_valid after", y_valid, 1'b0);
        check("bp x_ready after", x_ready, 1'b1);
        $display("xfer bp: X=2 Y=%0h held 5 cycles", Y);

        // 4: coefficient write during RUN is ignored
        // d=[3,2,0..], h=[1,2,..] -> 3*1+2*2=7
        offer(32'd3);
        @(posedge CLK);
        #1;
        tap_we    = 1'b1;
        tap_addr  = 4'd0;
        tap_wdata = 32'd99;
        @(posedge CLK);
        #1;
        tap_we    = 1'b0;
        wait_y(lat);
        check("run_wr Y", Y, 32'd7);
        check("run_wr Done", Done, 1'b1);
        results++;
        @(posedge CLK);
        #1;
        $display("xfer run_wr: X=3 Y=%0h", Y);
        // d=[0,3,2,..] -> 3*2+2*3=12
        xfer(32'd0, 32'd12, "run_wr next");

        // 5: signed extremes and output conversion
        do_reset();
        write_coef(4'd0, 32'h7FFF_FFFF);
`ifdef FIR_SAT_EN
        xfer(32'h7FFF_FFFF, 32'h7FFF_FFFF, "sat max");
`else
        xfer(32'h7FFF_FFFF, 32'h0000_0001, "wrap max");
`endif
        write_coef(4'd0, 32'hFFFF_FFFF);
        xfer(32'd5, 32'hFFFF_FFFB, "neg");

        // 6: reset in the middle of RUN discards the result
        do_reset();
        for (int k = 0; k < NTAP; k++) write_coef(4'(k), 32'd1);
        offer(32'd7);
        repeat (4) begin
            @(posedge CLK);
            #1;
        end
        Reset = 1'b1;
        #1;
        check("midrst y_valid", y_valid, 1'b0);
        check("midrst x_ready", x_ready, 1'b1);
        check("midrst Done", Done, 1'b0);
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        for (int k = 0; k < NTAP; k++) write_coef(4'(k), 32'd1);
        xfer(32'd1, 32'd1, "after rst");

        check("done count", done_cnt, results);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
